// File: rtl/bcd2bin_serial_pkg.sv
// Shared definitions for the serial BCD-to-binary converter.
package bcd2bin_serial_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  // A nibble is not a decimal digit when it exceeds 9.
  function automatic logic digit_bad(input logic [DIGIT_W-1:0] nib);
    return nib > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd2bin_serial_mul10_add.sv
// Combinational Horner step: y = a*10 + d using shifts and adds only.
module mul10_add #(
  parameter int W = 30
) (
  input  logic [W-1:0] a,
  input  logic [3:0]   d,
  output logic [W-1:0] y
);

  // a*10 = a*8 + a*2; truncation to W is intended, the caller checks the guard bits.
  always_comb begin
    y = (a << 3) + (a << 1) + {{(W-4){1'b0}}, d};
  end

endmodule

// File: rtl/bcd2bin_serial.sv
// Serial BCD-to-binary converter, one digit per clock, MSD first, with start/busy/done handshake.
module bcd2bin_serial
  import bcd2bin_serial_pkg::*;
#(
  parameter int BCD_DIGITS  = 8,
  parameter int BINARY_BITS = 26
) (
  input  logic                      vga_clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4*BCD_DIGITS-1:0]   bcd_in,
  output logic                      busy,
  output logic                      done,
  output logic [BINARY_BITS-1:0]    bin_out,
  output logic                      overflow,
  output logic                      err_digit
);

  // Four guard bits above the result catch the first step that leaves range exactly.
  localparam int ACC_W = BINARY_BITS + 4;
  localparam int CNT_W = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCD_DIGITS - 1);

  state_t                    state, state_nxt;
  logic [ACC_W-1:0]          acc, acc_step;
  logic                      ovf, ovf_step;
  logic [CNT_W-1:0]          count;
  logic [4*BCD_DIGITS-1:0]   digits;
  logic                      bad_in;
  logic                      accept;

  mul10_add #(.W(ACC_W)) u_step (
    .a (acc),
    .d (digits[4*BCD_DIGITS-1 -: DIGIT_W]),
    .y (acc_step)
  );

  // Sticky overflow including the step being taken now.
  assign ovf_step = ovf | (|acc_step[ACC_W-1:BINARY_BITS]);

  // Flag any non-decimal nibble in the incoming operand.
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (digit_bad(bcd_in[DIGIT_W*i +: DIGIT_W])) bad_in = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: accept in IDLE, invalid operands never leave IDLE, last digit returns to IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (!bad_in) state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (count == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and result registers: capture, Horner steps, and the one-cycle done pulse.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      count     <= '0;
      digits    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bin_out   <= '0;
      overflow  <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (bad_in) begin
          done      <= 1'b1;
          err_digit <= 1'b1;
          overflow  <= 1'b0;
          bin_out   <= '0;
        end else begin
          digits <= bcd_in;
          acc    <= '0;
          ovf    <= 1'b0;
          count  <= CNT_LAST;
          busy   <= 1'b1;
        end
      end else if (state == S_CONV) begin
        acc    <= acc_step;
        ovf    <= ovf_step;
        digits <= digits << DIGIT_W;
        count  <= count - CNT_W'(1);
        if (count == '0) begin
          done      <= 1'b1;
          busy      <= 1'b0;
          err_digit <= 1'b0;
          overflow  <= ovf_step;
          bin_out   <= ovf_step ? {BINARY_BITS{1'b1}} : acc_step[BINARY_BITS-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd2bin_serial.sv
// Self-checking bench for bcd2bin_serial: directed cases plus randomized traffic against a decimal model.
module tb_bcd2bin_serial;

  localparam int D = 8;
  localparam int B = 26;

  logic          vga_clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4*D-1:0] bcd_in;
  logic          busy, done, overflow, err_digit;
  logic [B-1:0]  bin_out;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model state: cycles left in the current conversion and the visible result registers.
  int           m_left;
  logic         m_done, m_ovf, m_err, p_ovf;
  logic [B-1:0] m_bin, p_bin;

  bcd2bin_serial #(.BCD_DIGITS(D), .BINARY_BITS(B)) dut (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .overflow  (overflow),
    .err_digit (err_digit)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Decimal value of the word; saturate when it does not fit in B bits.
  task automatic ref_conv(input logic [4*D-1:0] bcd, output logic [B-1:0] v,
                          output logic o, output logic e);
    longint val = 0;
    logic [3:0] nib;
    e = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (nib > 4'd9) e = 1'b1;
      val = val * 10 + longint'(nib);
    end
    o = 1'b0;
    v = '0;
    if (!e) begin
      if (val >= (longint'(1) << B)) begin
        o = 1'b1;
        v = '1;
      end else begin
        v = B'(val);
      end
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_done = 0; m_ovf = 0; m_err = 0; m_bin = '0; p_bin = '0; p_ovf = 0;
  endtask

  // Handshake rules per rising edge, using the inputs the bench is holding.
  task automatic model_edge();
    logic [B-1:0] v;
    logic o, e;
    if (rst) begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_bin = p_bin; m_ovf = p_ovf; m_err = 1'b0;
        end
      end else if (start) begin
        ref_conv(bcd_in, v, o, e);
        if (e) begin
          m_done = 1'b1; m_err = 1'b1; m_ovf = 1'b0; m_bin = '0;
        end else begin
          m_left = D; p_bin = v; p_ovf = o;
        end
      end
    end
  endtask

  // One clock: model advances at the edge, DUT is compared on the falling edge.
  task automatic step();
    @(posedge vga_clk);
    model_edge();
    @(negedge vga_clk);
    cycle++;
    check("busy", busy, m_left > 0);
    check("done", done, m_done);
    check("bin_out", bin_out, m_bin);
    check("overflow", overflow, m_ovf);
    check("err_digit", err_digit, m_err);
  endtask

  // Single start pulse; reports steps from accept to done and busy cycles seen.
  task automatic do_conv(input logic [4*D-1:0] bcd, output int lat, output int busy_n);
    bool_loop: begin end
    start = 1'b1; bcd_in = bcd;
    step();
    start = 1'b0; bcd_in = $urandom;
    lat = 0; busy_n = busy ? 1 : 0;
    while (!done && lat < 20) begin
      step();
      lat++;
      if (busy) busy_n++;
    end
    if (!done) check("done_wait", 0, 1);
  endtask

  function automatic logic [4*D-1:0] rand_bcd();
    logic [4*D-1:0] r;
    int sel;
    for (int i = 0; i < D; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0)     r[4*i +: 4] = 4'($urandom_range(10, 15));
      else if (sel < 5) r[4*i +: 4] = 4'd9;
      else              r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  initial begin
    int lat, bn, ndone, last_done, alt;
    int dcyc[$];
    logic [B-1:0] exp_alt;
    logic [B-1:0] v;
    logic o, e;

    rst = 1'b0; start = 1'b0; bcd_in = '0;
    model_reset();
    @(negedge vga_clk); @(negedge vga_clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bin", bin_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err_digit, 0);
    rst = 1'b1;
    step();

    // Model sanity pins.
    ref_conv(32'h12345678, v, o, e);
    check("model_12345678", v, 26'd12345678);
    ref_conv(32'h67108864, v, o, e);
    check("model_ovf", {o, v}, {1'b1, 26'h3FFFFFF});

    // 1. zero
    do_conv(32'h00000000, lat, bn);
    check("t1_lat", lat, 8);
    check("t1_bin", bin_out, 0);
    check("t1_ovf", overflow, 0);
    check("t1_err", err_digit, 0);

    // 2. 12345678
    do_conv(32'h12345678, lat, bn);
    check("t2_bin", bin_out, 26'h0BC614E);
    check("t2_busy_cycles", bn, 8);
    check("t2_lat", lat, 8);

    // 3. range boundary
    do_conv(32'h67108863, lat, bn);
    check("t3a_bin", bin_out, 26'h3FFFFFF);
    check("t3a_ovf", overflow, 0);
    do_conv(32'h67108864, lat, bn);
    check("t3b_bin", bin_out, 26'h3FFFFFF);
    check("t3b_ovf", overflow, 1);
    do_conv(32'h99999999, lat, bn);
    check("t3c_ovf", overflow, 1);

    // 4. invalid digit
    do_conv(32'h1234A678, lat, bn);
    check("t4_lat", lat, 0);
    check("t4_err", err_digit, 1);
    check("t4_bin", bin_out, 0);
    check("t4_busy", bn, 0);

    // 5. start held, alternating operands; junk on bcd_in while busy
    start = 1'b1; alt = 0; ndone = 0; last_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (m_left == 0) begin
        bcd_in = (alt == 0) ? 32'h00000001 : 32'h00000010;
        alt ^= 1;
      end else begin
        bcd_in = $urandom;
      end
      step();
      if (done) begin
        exp_alt = (ndone % 2 == 0) ? 26'd1 : 26'd10;
        check("t5_bin", bin_out, exp_alt);
        if (ndone > 0) check("t5_period", cycle - last_done, 9);
        last_done = cycle;
        ndone++;
      end
    end
    check("t5_ndone", ndone, 3);
    start = 1'b0;
    for (int c = 0; c < 10; c++) step();

    // Randomized traffic, including start pulses while busy.
    for (int c = 0; c < 500; c++) begin
      start  = ($urandom_range(0, 2) == 0);
      bcd_in = rand_bcd();
      step();
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) step();

    // 6. async reset mid-conversion
    do_conv(32'h99999999, lat, bn);
    start = 1'b1; bcd_in = 32'h12345678;
    step();
    start = 1'b0;
    for (int c = 0; c < 3; c++) step();
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_bin", bin_out, 0);
    check("t6_ovf", overflow, 0);
    check("t6_err", err_digit, 0);
    model_reset();
    step(); step();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) step();
    do_conv(32'h00000042, lat, bn);
    check("t6_bin42", bin_out, 26'd42);
    check("t6_lat", lat, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
